// File: rtl/sort_unit_param_if.sv
// sort_unit_param_if: host load/read and sort-control bundle for the selection sorter
interface sort_unit_param_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             start;
  logic             desc;
  logic [AW-1:0]    last;
  logic             wr;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] datain;
  logic [WIDTH-1:0] dataout;
  logic             ready;
  logic             done;
  logic [AW-1:0]    swap_cnt;
  modport master (
    output start, desc, last, wr, addr, datain,
    input  dataout, ready, done, swap_cnt
  );
  modport slave (
    input  start, desc, last, wr, addr, datain,
    output dataout, ready, done, swap_cnt
  );
endinterface

// File: rtl/sort_unit_param.sv
// sort_unit_param: in-place selection sorter over a private synchronous RAM, range 0..last, asc/desc
module sort_unit_param #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input logic              clk,
  input logic              nrst,
  sort_unit_param_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [2:0] READY = 3'd0;
  localparam logic [2:0] OUTER = 3'd1;
  localparam logic [2:0] INNER = 3'd2;
  localparam logic [2:0] ENDIN = 3'd3;
  localparam logic [2:0] SWAP  = 3'd4;
  logic [2:0]       state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] ival;
  logic [WIDTH-1:0] dataout;
  logic [AW-1:0]    i;
  logic [AW-1:0]    j;
  logic [AW-1:0]    mi;
  logic [AW-1:0]    last_q;
  logic [AW-1:0]    swap_cnt;
  logic [AW-1:0]    raddr;
  logic [AW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic             desc_q;
  logic             done;
  logic             host_rd;
  logic             host_wr;
  logic             mem_we;
  logic             better;
  assign bus.dataout  = dataout;
  assign bus.ready    = state == READY;
  assign bus.done     = done;
  assign bus.swap_cnt = swap_cnt;
  // Read address is pre-issued one cycle ahead: each state requests the word the next state consumes
  always_comb begin
    raddr   = state == READY ? (bus.start ? '0 : bus.addr) :
              state == INNER ? j + 1'b1 : i + 1'b1;
    host_rd = state == READY && !bus.start && !bus.wr;
    host_wr = state == READY && !bus.start && bus.wr;
    better  = desc_q ? rdata > m : rdata < m;
    mem_we  = host_wr || (state == ENDIN && mi != i) || state == SWAP;
    mem_wa  = state == READY ? bus.addr : state == SWAP ? i : mi;
    mem_wd  = state == READY ? bus.datain : state == SWAP ? m : ival;
  end
  // RAM array with a single write port and a registered read port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    rdata <= mem[raddr];
  end
  // Sequencer: outer pass picks i, inner scan tracks the extreme value m at mi, then swap
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= READY;
      i        <= '0;
      j        <= '0;
      mi       <= '0;
      m        <= '0;
      ival     <= '0;
      last_q   <= '0;
      desc_q   <= 1'b0;
      swap_cnt <= '0;
      done     <= 1'b0;
      dataout  <= '0;
    end else begin
      done <= state == OUTER && i == last_q;
      if (host_rd) dataout <= mem[raddr];
      case (state)
        READY: if (bus.start) begin
          desc_q   <= bus.desc;
          last_q   <= bus.last;
          swap_cnt <= '0;
          i        <= '0;
          state    <= OUTER;
        end
        OUTER: if (i == last_q) begin
          state <= READY;
        end else begin
          m     <= rdata;
          ival  <= rdata;
          mi    <= i;
          j     <= i + 1'b1;
          state <= INNER;
        end
        INNER: begin
          if (better) begin
            m  <= rdata;
            mi <= j;
          end
          if (j == last_q) state <= ENDIN;
          else j <= j + 1'b1;
        end
        ENDIN: if (mi == i) begin
          i     <= i + 1'b1;
          state <= OUTER;
        end else begin
          swap_cnt <= swap_cnt + 1'b1;
          state    <= SWAP;
        end
        SWAP: begin
          i     <= i + 1'b1;
          state <= OUTER;
        end
        default: state <= READY;
      endcase
    end
  end
endmodule
